// File: rtl/hm_pkg.sv
// Shared widths, instruction field positions, opcodes and FSM state encoding
// for the hm sequencer and its ALU.
package hm_pkg;

  localparam int PC_W     = 8;
  localparam int DATA_W   = 16;
  localparam int OPC_W    = 6;
  localparam int INSTR_W  = OPC_W + DATA_W;

  localparam int OPC_LSB  = DATA_W;
  localparam int OPR_LSB  = 0;
  localparam int ADDR_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP = 6'h00;
  localparam logic [OPC_W-1:0] OP_LDI = 6'h01;
  localparam logic [OPC_W-1:0] OP_LDA = 6'h02;
  localparam logic [OPC_W-1:0] OP_STA = 6'h03;
  localparam logic [OPC_W-1:0] OP_ADD = 6'h04;
  localparam logic [OPC_W-1:0] OP_SUB = 6'h05;
  localparam logic [OPC_W-1:0] OP_CMP = 6'h06;
  localparam logic [OPC_W-1:0] OP_JMP = 6'h07;
  localparam logic [OPC_W-1:0] OP_JEQ = 6'h08;
  localparam logic [OPC_W-1:0] OP_JC  = 6'h09;
  localparam logic [OPC_W-1:0] OP_HLT = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/hm_alu.sv
// Combinational add/subtract for ADD, SUB and CMP: result, carry/borrow, zero.
module hm_alu
  import hm_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] res,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide;

  // One extra bit: for subtraction it reads as the unsigned borrow (a < b).
  always_comb begin
    if (sub) wide = {1'b0, a} - {1'b0, b};
    else     wide = {1'b0, a} + {1'b0, b};
  end

  assign res   = wide[DATA_W-1:0];
  assign carry = wide[DATA_W];
  assign zero  = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/hm_sequencer.sv
// Multi-cycle instruction sequencer: owns PC and IR, decodes each instruction and
// drives data-memory, accumulator and status-flag writes (3 cycles per instruction).
//
// state  | meaning
// IDLE   | waiting for RUN after reset
// FETCH  | PC on instruction bus, IR loads at end of cycle
// DECODE | data address from IR driven so DR settles
// EXEC   | perform op, pulse write enables, update PC
// HALT   | stopped at HLT; needs RUN low then high to resume at PC+1
module hm_sequencer
  import hm_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               RUN,
  input  logic [INSTR_W-1:0] I,
  input  logic [DATA_W-1:0]  DR,
  input  logic [DATA_W-1:0]  AR,
  input  logic               EFF,
  input  logic               CFF,
  output logic [PC_W-1:0]    PC,
  output logic [PC_W-1:0]    DWA,
  output logic [DATA_W-1:0]  DW,
  output logic               DWE,
  output logic [DATA_W-1:0]  AW,
  output logic               AWE,
  output logic               EFW,
  output logic               CFW,
  output logic               HALTED
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q;
  logic               ef_q, cf_q;
  logic               armed_q, armed_d;

  logic [OPC_W-1:0]   opc;
  logic [DATA_W-1:0]  opr;
  logic [PC_W-1:0]    addr;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_sub, alu_carry, alu_zero;

  assign opc     = ir_q[OPC_LSB +: OPC_W];
  assign opr     = ir_q[OPR_LSB +: DATA_W];
  assign addr    = ir_q[ADDR_LSB +: PC_W];
  assign alu_sub = (opc != OP_ADD);

  hm_alu u_alu (
    .a     (AR),
    .b     (DR),
    .sub   (alu_sub),
    .res   (alu_res),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ef_q    <= 1'b0;
      cf_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ef_q    <= EFW;
      cf_q    <= CFW;
      armed_q <= armed_d;
      if (state_q == ST_FETCH) ir_q <= I;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    armed_d = armed_q;
    AW      = '0;
    AWE     = 1'b0;
    DWE     = 1'b0;
    EFW     = ef_q;
    CFW     = cf_q;
    case (state_q)
      ST_IDLE:   if (RUN) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (opc)
          OP_LDI: begin AW = opr; AWE = 1'b1; end
          OP_LDA: begin AW = DR;  AWE = 1'b1; end
          OP_STA: DWE = 1'b1;
          OP_ADD, OP_SUB: begin
            AW  = alu_res;
            AWE = 1'b1;
            EFW = alu_zero;
            CFW = alu_carry;
          end
          OP_CMP: begin
            EFW = alu_zero;
            CFW = alu_carry;
          end
          OP_JMP: pc_d = addr;
          OP_JEQ: if (EFF) pc_d = addr;
          OP_JC:  if (CFF) pc_d = addr;
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
            armed_d = 1'b0;
          end
          default: ;
        endcase
      end
      // Resume only on a fresh RUN assertion, not a level left high since HLT.
      ST_HALT: begin
        if (!RUN) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = ST_FETCH;
          pc_d    = pc_q + PC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign PC     = pc_q;
  assign DWA    = addr;
  assign DW     = AR;
  assign HALTED = (state_q == ST_HALT);

endmodule

// File: tb/tb_hm_sequencer.sv
// Bench for hm_sequencer: directed vector table, hand-written program/halt/reset
// sequences and a random program checked against an instruction-level model.
module tb_hm_sequencer;
  import hm_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        RUN = 1'b0;
  logic [21:0] I;
  logic [15:0] DR, AR;
  logic        EFF, CFF;
  logic [7:0]  PC, DWA;
  logic [15:0] DW, AW;
  logic        DWE, AWE, EFW, CFW, HALTED;

  always #5 CLK = ~CLK;

  hm_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .I(I), .DR(DR), .AR(AR),
    .EFF(EFF), .CFF(CFF), .PC(PC), .DWA(DWA), .DW(DW), .DWE(DWE),
    .AW(AW), .AWE(AWE), .EFW(EFW), .CFW(CFW), .HALTED(HALTED)
  );

  // environment: instruction/data memories, accumulator and status register
  logic        use_tbl = 1'b0;
  logic [21:0] tbl_i = '0;
  logic [15:0] tbl_ar = '0, tbl_dr = '0;
  logic        tbl_eff = 1'b0, tbl_cff = 1'b0;
  logic [21:0] imem [256];
  logic [15:0] dinit [256];
  logic [15:0] dmem [256];
  logic [15:0] env_acc;
  logic        env_ef, env_cf;

  assign I   = use_tbl ? tbl_i   : imem[PC];
  assign DR  = use_tbl ? tbl_dr  : dmem[DWA];
  assign AR  = use_tbl ? tbl_ar  : env_acc;
  assign EFF = use_tbl ? tbl_eff : env_ef;
  assign CFF = use_tbl ? tbl_cff : env_cf;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      env_acc <= '0;
      env_ef  <= 1'b0;
      env_cf  <= 1'b0;
      for (int k = 0; k < 256; k++) dmem[k] <= dinit[k];
    end else begin
      if (DWE) dmem[DWA] <= DW;
      if (AWE) env_acc <= AW;
      env_ef <= EFW;
      env_cf <= CFW;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // instruction-level reference model
  logic [7:0]  m_pc;
  logic [15:0] m_acc;
  logic        m_ef, m_cf;
  logic [15:0] m_dmem [256];

  function automatic logic [21:0] mk(input logic [5:0] op, input logic [15:0] opr);
    return {op, opr};
  endfunction

  task automatic do_reset;
    #1 RST_N = 1'b0;
    RUN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    m_pc = '0; m_acc = '0; m_ef = 1'b0; m_cf = 1'b0;
    for (int k = 0; k < 256; k++) m_dmem[k] = dinit[k];
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Runs one instruction from its FETCH cycle to the next FETCH (or HALT).
  task automatic step_instr;
    logic [21:0] ins;
    logic [5:0]  opc;
    logic [15:0] opr, d, e_aw;
    logic [7:0]  a, npc;
    logic        e_awe, e_dwe, e_ef, e_cf, hlt;
    int          s;
    ins = imem[m_pc];
    opc = ins[21:16]; opr = ins[15:0]; a = ins[7:0]; d = m_dmem[a];
    chk("fetch_pc", 32'(PC), 32'(m_pc));
    chk("fetch_en", 32'({AWE, DWE}), 32'd0);
    tick;
    chk("decode_en", 32'({AWE, DWE}), 32'd0);
    chk("decode_dwa", 32'(DWA), 32'(a));
    tick;
    e_awe = 1'b0; e_dwe = 1'b0; e_aw = '0; e_ef = m_ef; e_cf = m_cf; hlt = 1'b0;
    npc = m_pc + 8'd1;
    case (opc)
      6'h01: begin e_awe = 1'b1; e_aw = opr; end
      6'h02: begin e_awe = 1'b1; e_aw = d; end
      6'h03: e_dwe = 1'b1;
      6'h04: begin
        s = int'(m_acc) + int'(d);
        e_awe = 1'b1; e_aw = 16'(s % 65536); e_cf = (s > 65535); e_ef = (e_aw == 16'd0);
      end
      6'h05, 6'h06: begin
        e_awe = (opc == 6'h05); e_cf = (m_acc < d);
        s = (int'(m_acc) - int'(d) + 65536) % 65536;
        e_ef = (s == 0);
        if (e_awe) e_aw = 16'(s);
      end
      6'h07: npc = a;
      6'h08: if (m_ef) npc = a;
      6'h09: if (m_cf) npc = a;
      6'h3F: begin npc = m_pc; hlt = 1'b1; end
      default: ;
    endcase
    chk("exec_awe", 32'(AWE), 32'(e_awe));
    chk("exec_dwe", 32'(DWE), 32'(e_dwe));
    if (e_awe) chk("exec_aw", 32'(AW), 32'(e_aw));
    if (e_dwe) chk("exec_dw", 32'(DW), 32'(m_acc));
    chk("exec_efw", 32'(EFW), 32'(e_ef));
    chk("exec_cfw", 32'(CFW), 32'(e_cf));
    if (e_dwe) m_dmem[a] = m_acc;
    if (e_awe) m_acc = e_aw;
    m_ef = e_ef; m_cf = e_cf; m_pc = npc;
    tick;
    chk("acc", 32'(env_acc), 32'(m_acc));
    chk("halted", 32'(HALTED), 32'(hlt));
  endtask

  typedef struct {
    logic [21:0] i;
    logic [15:0] ar, dr;
    logic        eff, cff;
    logic        awe;
    logic [15:0] aw;
    logic        dwe, efw, cfw, taken;
  } vec_t;

  function automatic vec_t mkv(input logic [21:0] i, input logic [15:0] ar, input logic [15:0] dr,
                               input logic eff, input logic cff, input logic awe,
                               input logic [15:0] aw, input logic dwe, input logic efw,
                               input logic cfw, input logic taken);
    vec_t v;
    v.i = i; v.ar = ar; v.dr = dr; v.eff = eff; v.cff = cff; v.awe = awe;
    v.aw = aw; v.dwe = dwe; v.efw = efw; v.cfw = cfw; v.taken = taken;
    return v;
  endfunction

  vec_t tv [18];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_pc;
    logic [5:0] rop;
    int         r;

    //          instr               ar       dr       eff cff awe aw       dwe efw cfw taken
    tv[0]  = mkv(mk(6'h00, 16'h0000), 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    tv[1]  = mkv(mk(6'h01, 16'h1234), 16'h0000, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 0, 0);
    tv[2]  = mkv(mk(6'h04, 16'h0021), 16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 0, 1, 1, 0);
    tv[3]  = mkv(mk(6'h15, 16'h0033), 16'h0007, 16'h0009, 0, 0, 0, 16'h0000, 0, 1, 1, 0);
    tv[4]  = mkv(mk(6'h05, 16'h0001), 16'h0003, 16'h0005, 0, 0, 1, 16'hFFFE, 0, 0, 1, 0);
    tv[5]  = mkv(mk(6'h06, 16'h0002), 16'h0005, 16'h0005, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    tv[6]  = mkv(mk(6'h03, 16'h0010), 16'hABCD, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 0, 0);
    tv[7]  = mkv(mk(6'h02, 16'h0020), 16'h0000, 16'h5A5A, 0, 0, 1, 16'h5A5A, 0, 1, 0, 0);
    tv[8]  = mkv(mk(6'h08, 16'h0040), 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 1);
    tv[9]  = mkv(mk(6'h08, 16'h0050), 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 0);
    tv[10] = mkv(mk(6'h09, 16'h0060), 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 1);
    tv[11] = mkv(mk(6'h09, 16'h0070), 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 0);
    tv[12] = mkv(mk(6'h07, 16'h00FF), 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 1);
    tv[13] = mkv(mk(6'h00, 16'h0000), 16'h1111, 16'h2222, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    tv[14] = mkv(mk(6'h04, 16'h0003), 16'h8000, 16'h8000, 0, 0, 1, 16'h0000, 0, 1, 1, 0);
    tv[15] = mkv(mk(6'h05, 16'h0004), 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0, 0);
    tv[16] = mkv(mk(6'h06, 16'h0005), 16'h0005, 16'h0006, 0, 0, 0, 16'h0000, 0, 0, 1, 0);
    tv[17] = mkv(mk(6'h00, 16'h0000), 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 0);

    for (int k = 0; k < 256; k++) begin imem[k] = '0; dinit[k] = '0; end

    // ---- table phase: inputs driven straight from the vector table
    use_tbl = 1'b1;
    do_reset;
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_halted", 32'(HALTED), 32'd0);
    chk("rst_en", 32'({AWE, DWE}), 32'd0);
    chk("rst_aw", 32'(AW), 32'd0);
    chk("rst_flags", 32'({EFW, CFW}), 32'd0);
    tick;
    chk("idle_pc", 32'(PC), 32'd0);
    RUN = 1'b1;
    tick;
    exp_pc = 8'h00;
    for (int v = 0; v < 18; v++) begin
      tbl_i = tv[v].i; tbl_ar = tv[v].ar; tbl_dr = tv[v].dr;
      tbl_eff = tv[v].eff; tbl_cff = tv[v].cff;
      chk($sformatf("v%0d_pc", v), 32'(PC), 32'(exp_pc));
      chk($sformatf("v%0d_fetch_en", v), 32'({AWE, DWE}), 32'd0);
      tick;
      chk($sformatf("v%0d_dwa", v), 32'(DWA), 32'(tv[v].i[7:0]));
      chk($sformatf("v%0d_decode_en", v), 32'({AWE, DWE}), 32'd0);
      tick;
      chk($sformatf("v%0d_awe", v), 32'(AWE), 32'(tv[v].awe));
      chk($sformatf("v%0d_aw", v), 32'(AW), 32'(tv[v].aw));
      chk($sformatf("v%0d_dwe", v), 32'(DWE), 32'(tv[v].dwe));
      if (tv[v].dwe) chk($sformatf("v%0d_dw", v), 32'(DW), 32'(tv[v].ar));
      chk($sformatf("v%0d_efw", v), 32'(EFW), 32'(tv[v].efw));
      chk($sformatf("v%0d_cfw", v), 32'(CFW), 32'(tv[v].cfw));
      exp_pc = tv[v].taken ? tv[v].i[7:0] : exp_pc + 8'd1;
      tick;
    end
    chk("tbl_final_pc", 32'(PC), 32'(exp_pc));

    // ---- reset in the middle of STA's EXEC cycle
    tbl_i = mk(6'h03, 16'h0033); tbl_ar = 16'h4242;
    tick;
    tick;
    chk("sta_dwe_before_rst", 32'(DWE), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_dwe", 32'(DWE), 32'd0);
    chk("rst_mid_awe", 32'(AWE), 32'd0);
    chk("rst_mid_pc", 32'(PC), 32'd0);
    chk("rst_mid_halted", 32'(HALTED), 32'd0);
    RUN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick;
    tick;
    chk("rst_idle_pc", 32'(PC), 32'd0);
    chk("rst_idle_en", 32'({AWE, DWE}), 32'd0);

    // ---- directed program on the memory environment
    use_tbl = 1'b0;
    imem[8'h00] = mk(6'h01, 16'h1234);
    imem[8'h01] = mk(6'h03, 16'h0010);
    imem[8'h02] = mk(6'h02, 16'h0010);
    imem[8'h03] = mk(6'h01, 16'hFFFF);
    imem[8'h04] = mk(6'h04, 16'h0021);
    imem[8'h05] = mk(6'h09, 16'h0020);
    imem[8'h20] = mk(6'h01, 16'h0005);
    imem[8'h21] = mk(6'h06, 16'h0022);
    imem[8'h22] = mk(6'h08, 16'h0008);
    imem[8'h08] = mk(6'h06, 16'h0023);
    imem[8'h09] = mk(6'h08, 16'h0030);
    imem[8'h0A] = mk(6'h3F, 16'h0000);
    imem[8'h0B] = mk(6'h07, 16'h00FF);
    imem[8'hFF] = mk(6'h00, 16'h0000);
    dinit[8'h21] = 16'h0001;
    dinit[8'h22] = 16'h0005;
    dinit[8'h23] = 16'h0006;
    do_reset;
    RUN = 1'b1;
    tick;
    repeat (3) step_instr;
    chk("prog_d10", 32'(dmem[8'h10]), 32'h1234);
    chk("prog_acc_lda", 32'(env_acc), 32'h1234);
    repeat (2) step_instr;
    chk("prog_add_acc", 32'(env_acc), 32'h0000);
    chk("prog_add_flags", 32'({env_ef, env_cf}), 32'h3);
    step_instr;
    chk("prog_jc_pc", 32'(PC), 32'h20);
    repeat (2) step_instr;
    chk("prog_cmp_acc", 32'(env_acc), 32'h0005);
    chk("prog_cmp_flags", 32'({env_ef, env_cf}), 32'h2);
    step_instr;
    chk("prog_jeq_taken", 32'(PC), 32'h08);
    step_instr;
    chk("prog_cmp6_flags", 32'({env_ef, env_cf}), 32'h1);
    step_instr;
    chk("prog_jeq_not", 32'(PC), 32'h0A);
    step_instr;
    chk("halt_flag", 32'(HALTED), 32'd1);
    repeat (4) tick;
    chk("halt_frozen_pc", 32'(PC), 32'h0A);
    chk("halt_held_run", 32'(HALTED), 32'd1);
    RUN = 1'b0;
    tick;
    chk("halt_run_low", 32'(HALTED), 32'd1);
    RUN = 1'b1;
    tick;
    chk("resume_halted", 32'(HALTED), 32'd0);
    chk("resume_pc", 32'(PC), 32'h0B);
    m_pc = 8'h0B;
    repeat (2) step_instr;
    chk("wrap_pc", 32'(PC), 32'h00);
    step_instr;

    // ---- random program against the instruction-level model
    for (int k = 0; k < 256; k++) begin
      r = $urandom_range(0, 10);
      rop = (r == 10) ? 6'h15 : 6'(r);
      imem[k]  = mk(rop, 16'($urandom));
      dinit[k] = 16'($urandom);
    end
    do_reset;
    RUN = 1'b1;
    tick;
    for (int n = 0; n < 300; n++) begin
      if (n % 37 == 5) RUN = 1'b0;
      if (n % 37 == 6) RUN = 1'b1;
      step_instr;
    end
    for (int k = 0; k < 256; k++)
      if (dmem[k] !== m_dmem[k]) chk($sformatf("rand_dmem_%0h", k), 32'(dmem[k]), 32'(m_dmem[k]));
    chk("rand_acc_final", 32'(env_acc), 32'(m_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
